// File: rtl/coin_acceptor_if.sv
// Coin-sensor front end bundle: raw sensor lines in, clean coin pulses and count out.
// Latency: none, wires only.
// Backpressure: none; the sensor side cannot be stalled.
interface coin_acceptor_if;
  logic       nickle_raw;
  logic       dime_raw;
  logic       nickle;
  logic       dime;
  logic       reject;
  logic [7:0] coin_count;

  // Side that drives the sensors and watches the pulses (vending FSM / testbench)
  modport master (
    output nickle_raw, dime_raw,
    input  nickle, dime, reject, coin_count
  );

  // The acceptor itself
  modport slave (
    input  nickle_raw, dime_raw,
    output nickle, dime, reject, coin_count
  );
endinterface

// File: rtl/coin_acceptor.sv
// Synchronises and debounces raw coin sensors into spaced one-cycle nickle/dime pulses.
// Latency: raw edge sampled at edge k gives a pulse at edge k+DEBOUNCE+4 when idle.
// Backpressure: one queue slot per coin type; a coin arriving with its slot full is rejected.
module coin_acceptor #(
  parameter int DEBOUNCE = 4,
  parameter int HOLDOFF  = 2
) (
  input logic           clk,
  input logic           reset,
  coin_acceptor_if.slave bus
);

  localparam int DW = $clog2(DEBOUNCE + 1);
  localparam int GW = $clog2(HOLDOFF + 1);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] GAP  = 1'b1;

  // Channel index 0 is the nickel, 1 is the dime throughout.
  logic [1:0]    s1;
  logic [1:0]    s2;
  logic [1:0]    stable;
  logic [1:0]    stable_d;
  logic [1:0]    rise;
  logic [1:0]    pend;
  logic [DW-1:0] db_cnt [2];

  logic [0:0]    state;
  logic [GW-1:0] gap_cnt;
  logic          emit_n;
  logic          emit_d;
  logic [1:0]    clr;
  logic          nickle_pulse;
  logic          dime_pulse;
  logic          reject_pulse;
  logic [7:0]    count;

  // Two-flop synchroniser; nothing else looks at the raw lines or the first stage
  always_ff @(posedge clk) begin
    if (reset) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= {bus.dime_raw, bus.nickle_raw};
      s2 <= s1;
    end
  end

  // Debounce: a level must disagree with stable for DEBOUNCE straight cycles to be taken
  always_ff @(posedge clk) begin
    if (reset) begin
      stable   <= '0;
      stable_d <= '0;
      rise     <= '0;
      for (int i = 0; i < 2; i++) db_cnt[i] <= '0;
    end else begin
      stable_d <= stable;
      rise     <= stable & ~stable_d;
      for (int i = 0; i < 2; i++) begin
        if (s2[i] == stable[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DW'(DEBOUNCE - 1)) begin
          stable[i] <= ~stable[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + 1'b1;
        end
      end
    end
  end

  // Emit decision from the idle state; nickel wins when both are waiting
  always_comb begin
    emit_n = (state == IDLE) && pend[0];
    emit_d = (state == IDLE) && !pend[0] && pend[1];
    clr    = {emit_d, emit_n};
  end

  // Pending slots: a rise fills an empty slot, a rise into a full slot is bounced
  always_ff @(posedge clk) begin
    if (reset) begin
      pend         <= '0;
      reject_pulse <= 1'b0;
    end else begin
      reject_pulse <= |(rise & pend);
      for (int i = 0; i < 2; i++) begin
        if (rise[i] && !pend[i]) pend[i] <= 1'b1;
        else if (clr[i])         pend[i] <= 1'b0;
      end
    end
  end

  // Emitter: one pulse, then HOLDOFF quiet cycles so the vending FSM can keep up
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      gap_cnt      <= '0;
      nickle_pulse <= 1'b0;
      dime_pulse   <= 1'b0;
    end else begin
      nickle_pulse <= emit_n;
      dime_pulse   <= emit_d;
      case (state)
        IDLE: begin
          if (emit_n || emit_d) begin
            state   <= GAP;
            gap_cnt <= '0;
          end
        end
        GAP: begin
          if (gap_cnt == GW'(HOLDOFF - 1)) begin
            state   <= IDLE;
            gap_cnt <= '0;
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Accepted-coin counter, free-running modulo 256
  always_ff @(posedge clk) begin
    if (reset)                         count <= '0;
    else if (nickle_pulse | dime_pulse) count <= count + 1'b1;
  end

  assign bus.nickle     = nickle_pulse;
  assign bus.dime       = dime_pulse;
  assign bus.reject     = reject_pulse;
  assign bus.coin_count = count;

endmodule
